// File: rtl/fixed_point_pkg.sv
// Shared Q-format definitions for the fixed-point multiplier and divider:
// the sequencer state encoding and width helpers.
package fixed_point_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_CALC  = 3'd2,
        ST_ROUND = 3'd3,
        ST_SIGN  = 3'd4
    } fp_state_e;

    // Magnitude width of a sign-magnitude operand.
    function automatic int fp_widthu(input int width);
        return width - 1;
    endfunction

    // Most negative two's-complement value (1 followed by zeros); it has no magnitude counterpart.
    function automatic logic [63:0] fp_smallest(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/fixed_point_round_half_even.sv
// Combinational round-half-to-even of an unsigned value by FBITS fractional bits,
// with overflow when the rounded magnitude does not fit in MAG_W bits.
module fixed_point_round_half_even #(
    parameter int IN_W  = 14,
    parameter int FBITS = 4,
    parameter int MAG_W = 7
) (
    input  logic [IN_W-1:0]  value,
    output logic [MAG_W-1:0] o_mag,
    output logic             o_ovf
);

    localparam int TW = IN_W - FBITS + 1;

    logic [TW-1:0] trunc_s;
    logic [TW-1:0] rounded_s;
    logic          round_up_s;

    generate
        if (FBITS == 0) begin : g_no_frac
            assign trunc_s    = {1'b0, value};
            assign round_up_s = 1'b0;
        end else begin : g_frac
            logic guard_s;
            logic sticky_s;
            assign trunc_s = {1'b0, value[IN_W-1:FBITS]};
            assign guard_s = value[FBITS-1];
            if (FBITS == 1) begin : g_no_sticky
                assign sticky_s = 1'b0;
            end else begin : g_sticky
                assign sticky_s = |value[FBITS-2:0];
            end
            // An exact tie rounds up only when that makes the result even.
            assign round_up_s = guard_s & (trunc_s[0] | sticky_s);
        end
    endgenerate

    assign rounded_s = trunc_s + {{(TW-1){1'b0}}, round_up_s};
    assign o_ovf     = |(rounded_s >> MAG_W);
    assign o_mag     = rounded_s[MAG_W-1:0];

endmodule

// File: rtl/simple_fixed_point_signed_multiplier.sv
// Sequential signed Q(WIDTH-FBITS).FBITS multiplier: shift-and-add on magnitudes,
// round-half-to-even, overflow flag. Define MULT_SATURATE_EN to saturate on overflow.
module simple_fixed_point_signed_multiplier
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FBITS = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_valid,
    output logic                    o_ovf,
    output logic signed [WIDTH-1:0] o_val
);

    localparam int              WIDTHU   = fp_widthu(WIDTH);
    localparam int              PW       = 2 * WIDTHU;
    localparam int              CNT_W    = $clog2(WIDTHU);
    localparam logic [WIDTH-1:0] SMALLEST = WIDTH'(fp_smallest(WIDTH));
    localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(WIDTHU - 1);

    fp_state_e         state_r, state_s;
    logic [WIDTHU-1:0] au_r, au_s, bu_r, bu_s, mag_r, mag_s;
    logic [PW-1:0]     prod_r, prod_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              sig_diff_r, sig_diff_s, rovf_r, rovf_s;
    logic              busy_r, busy_s, done_r, done_s, valid_r, valid_s, ovf_r, ovf_s;
    logic [WIDTH-1:0]  val_r, val_s;
    logic [WIDTHU-1:0] rnd_mag_s;
    logic              rnd_ovf_s;

    function automatic logic [WIDTHU-1:0] abs_mag(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] t;
        if (v[WIDTH-1]) begin
            t = (~v) + {{WIDTHU{1'b0}}, 1'b1};
        end else begin
            t = v;
        end
        return t[WIDTHU-1:0];
    endfunction

`ifdef MULT_SATURATE_EN
    function automatic logic [WIDTH-1:0] sat_value(input logic neg);
        if (neg) begin
            return {1'b1, {(WIDTHU-1){1'b0}}, 1'b1};
        end else begin
            return {1'b0, {WIDTHU{1'b1}}};
        end
    endfunction
`endif

    fixed_point_round_half_even #(
        .IN_W (PW),
        .FBITS(FBITS),
        .MAG_W(WIDTHU)
    ) u_round (
        .value(prod_r),
        .o_mag(rnd_mag_s),
        .o_ovf(rnd_ovf_s)
    );

    // Next-state and next-output logic for the multiply sequencer.
    always_comb begin
        state_s    = state_r;
        au_s       = au_r;
        bu_s       = bu_r;
        mag_s      = mag_r;
        prod_s     = prod_r;
        cnt_s      = cnt_r;
        sig_diff_s = sig_diff_r;
        rovf_s     = rovf_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        valid_s    = valid_r;
        ovf_s      = ovf_r;
        val_s      = val_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    valid_s = 1'b0;
                    ovf_s   = 1'b0;
                    if ((a == SMALLEST) || (b == SMALLEST)) begin
                        done_s = 1'b1;
                        ovf_s  = 1'b1;
`ifdef MULT_SATURATE_EN
                        val_s   = sat_value(a[WIDTH-1] ^ b[WIDTH-1]);
                        valid_s = 1'b1;
`endif
                    end else begin
                        au_s       = abs_mag(a);
                        bu_s       = abs_mag(b);
                        sig_diff_s = a[WIDTH-1] ^ b[WIDTH-1];
                        busy_s     = 1'b1;
                        state_s    = ST_INIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_INIT: begin
                prod_s  = {PW{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
                state_s = ST_CALC;
            end
            ST_CALC: begin
                if (bu_r[cnt_r]) begin
                    prod_s = prod_r + ({{WIDTHU{1'b0}}, au_r} << cnt_r);
                end else begin
                    prod_s = prod_r;
                end
                if (cnt_r == LAST_IT) begin
                    state_s = ST_ROUND;
                end else begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_ROUND: begin
                mag_s   = rnd_mag_s;
                rovf_s  = rnd_ovf_s;
                state_s = ST_SIGN;
            end
            ST_SIGN: begin
                busy_s  = 1'b0;
                done_s  = 1'b1;
                state_s = ST_IDLE;
                if (!rovf_r) begin
                    // A zero magnitude stays positive regardless of operand signs.
                    if (sig_diff_r && (mag_r != {WIDTHU{1'b0}})) begin
                        val_s = (~{1'b0, mag_r}) + {{WIDTHU{1'b0}}, 1'b1};
                    end else begin
                        val_s = {1'b0, mag_r};
                    end
                    valid_s = 1'b1;
                end else begin
                    ovf_s = 1'b1;
`ifdef MULT_SATURATE_EN
                    val_s   = sat_value(sig_diff_r);
                    valid_s = 1'b1;
`else
                    valid_s = 1'b0;
`endif
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and registered-output update with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            au_r       <= {WIDTHU{1'b0}};
            bu_r       <= {WIDTHU{1'b0}};
            mag_r      <= {WIDTHU{1'b0}};
            prod_r     <= {PW{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            sig_diff_r <= 1'b0;
            rovf_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            valid_r    <= 1'b0;
            ovf_r      <= 1'b0;
            val_r      <= {WIDTH{1'b0}};
        end else begin
            state_r    <= state_s;
            au_r       <= au_s;
            bu_r       <= bu_s;
            mag_r      <= mag_s;
            prod_r     <= prod_s;
            cnt_r      <= cnt_s;
            sig_diff_r <= sig_diff_s;
            rovf_r     <= rovf_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            valid_r    <= valid_s;
            ovf_r      <= ovf_s;
            val_r      <= val_s;
        end
    end

    assign o_busy  = busy_r;
    assign o_done  = done_r;
    assign o_valid = valid_r;
    assign o_ovf   = ovf_r;
    assign o_val   = val_r;

endmodule

// File: tb/tb_simple_fixed_point_signed_multiplier.sv
// Directed self-checking bench for simple_fixed_point_signed_multiplier, WIDTH=8, FBITS=4.
module tb_simple_fixed_point_signed_multiplier;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_start = 1'b0;
    logic signed [7:0] a = 8'sh00;
    logic signed [7:0] b = 8'sh00;
    logic              o_busy, o_done, o_valid, o_ovf;
    logic signed [7:0] o_val;

    int tests_run = 0;
    int tests_failed = 0;

    simple_fixed_point_signed_multiplier #(.WIDTH(8), .FBITS(4)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_start(i_start),
        .a      (a),
        .b      (b),
        .o_busy (o_busy),
        .o_done (o_done),
        .o_valid(o_valid),
        .o_ovf  (o_ovf),
        .o_val  (o_val)
    );

    always #5 i_clk = ~i_clk;

    // Called 1 time unit after a rising edge; returns the edge after which o_done was seen (0 on timeout).
    task automatic do_mult(input logic [7:0] av, input logic [7:0] bv, output int done_edge, output int busy_cnt);
        a = av;
        b = bv;
        i_start = 1'b1;
        done_edge = 0;
        busy_cnt = 0;
        for (int e = 1; (e <= 20) && (done_edge == 0); e++) begin
            @(posedge i_clk);
            #1;
            if (e == 1) i_start = 1'b0;
            if (o_busy) busy_cnt++;
            if (o_done) done_edge = e;
        end
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if ({o_busy, o_done, o_valid, o_ovf, o_val} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_state: got %h expected 000", {o_busy, o_done, o_valid, o_ovf, o_val});
        end
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic test_basic();
        int de, bc;
        do_mult(8'h28, 8'h18, de, bc);
        tests_run++;
        if (de !== 11) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d expected 11", de);
        end
        tests_run++;
        if (bc !== 10) begin
            tests_failed++;
            $display("FAIL basic_busy_edges: got %0d expected 10", bc);
        end
        tests_run++;
        if ({o_valid, o_ovf, o_busy, o_val} !== 11'h43C) begin
            tests_failed++;
            $display("FAIL basic_result: got %h expected 43c", {o_valid, o_ovf, o_busy, o_val});
        end
        @(posedge i_clk);
        #1;
        tests_run++;
        if (o_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_pulse_width: got %b expected 0", o_done);
        end
    endtask

    task automatic test_signs();
        logic [7:0] va [4] = '{8'hD8, 8'hD8, 8'h7F, 8'h00};
        logic [7:0] vb [4] = '{8'h18, 8'hE8, 8'h10, 8'hE8};
        logic [7:0] ex [4] = '{8'hC4, 8'h3C, 8'h7F, 8'h00};
        int de, bc;
        for (int i = 0; i < 4; i++) begin
            do_mult(va[i], vb[i], de, bc);
            tests_run++;
            if ({de[4:0], o_valid, o_ovf, o_val} !== {5'd11, 1'b1, 1'b0, ex[i]}) begin
                tests_failed++;
                $display("FAIL signs_%0d: got edge %0d v%b o%b %h expected edge 11 v1 o0 %h", i, de, o_valid, o_ovf, o_val, ex[i]);
            end
        end
    endtask

    task automatic test_rounding();
        logic [7:0] va [4] = '{8'h01, 8'h01, 8'h03, 8'hFF};
        logic [7:0] vb [4] = '{8'h18, 8'h08, 8'h03, 8'h18};
        logic [7:0] ex [4] = '{8'h02, 8'h00, 8'h01, 8'hFE};
        int de, bc;
        for (int i = 0; i < 4; i++) begin
            do_mult(va[i], vb[i], de, bc);
            tests_run++;
            if ({o_valid, o_ovf, o_val} !== {1'b1, 1'b0, ex[i]}) begin
                tests_failed++;
                $display("FAIL round_%0d: got v%b o%b %h expected v1 o0 %h", i, o_valid, o_ovf, o_val, ex[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] va [3] = '{8'h40, 8'h55, 8'hC0};
        logic [7:0] vb [3] = '{8'h20, 8'h18, 8'h20};
        int de, bc;
        logic [7:0] exp_val;
        for (int i = 0; i < 3; i++) begin
            do_mult(8'h28, 8'h18, de, bc);
            do_mult(va[i], vb[i], de, bc);
`ifdef MULT_SATURATE_EN
            exp_val = (i == 2) ? 8'h81 : 8'h7F;
            tests_run++;
            if ({de[4:0], o_valid, o_ovf, o_val} !== {5'd11, 1'b1, 1'b1, exp_val}) begin
                tests_failed++;
                $display("FAIL ovf_%0d: got edge %0d v%b o%b %h expected edge 11 v1 o1 %h", i, de, o_valid, o_ovf, o_val, exp_val);
            end
`else
            exp_val = 8'h3C;
            tests_run++;
            if ({de[4:0], o_valid, o_ovf, o_val} !== {5'd11, 1'b0, 1'b1, exp_val}) begin
                tests_failed++;
                $display("FAIL ovf_%0d: got edge %0d v%b o%b %h expected edge 11 v0 o1 %h", i, de, o_valid, o_ovf, o_val, exp_val);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        int de, bc;
        logic [7:0] exp_val;
        logic       exp_valid;
        do_mult(8'h28, 8'h18, de, bc);
        a = 8'h80;
        b = 8'h10;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
`ifdef MULT_SATURATE_EN
        exp_val = 8'h81;
        exp_valid = 1'b1;
`else
        exp_val = 8'h3C;
        exp_valid = 1'b0;
`endif
        tests_run++;
        if ({o_done, o_ovf, o_busy, o_valid, o_val} !== {1'b1, 1'b1, 1'b0, exp_valid, exp_val}) begin
            tests_failed++;
            $display("FAIL smallest_reject: got d%b o%b b%b v%b %h expected d1 o1 b0 v%b %h", o_done, o_ovf, o_busy, o_valid, o_val, exp_valid, exp_val);
        end
        do_mult(8'h10, 8'h10, de, bc);
        tests_run++;
        if ({de[4:0], o_valid, o_ovf, o_val} !== {5'd11, 1'b1, 1'b0, 8'h10}) begin
            tests_failed++;
            $display("FAIL back_to_back: got edge %0d v%b o%b %h expected edge 11 v1 o0 10", de, o_valid, o_ovf, o_val);
        end
    endtask

    task automatic test_reset_mid();
        int de, bc;
        int seen_done;
        a = 8'h28;
        b = 8'h18;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        #1;
        tests_run++;
        if ({o_busy, o_done, o_valid, o_ovf, o_val} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_mid: got %h expected 000", {o_busy, o_done, o_valid, o_ovf, o_val});
        end
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        seen_done = 0;
        repeat (15) begin
            @(posedge i_clk);
            #1;
            if (o_done || o_busy) seen_done++;
        end
        tests_run++;
        if (seen_done !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", seen_done);
        end
        do_mult(8'h28, 8'h18, de, bc);
        tests_run++;
        if ({de[4:0], o_valid, o_ovf, o_val} !== {5'd11, 1'b1, 1'b0, 8'h3C}) begin
            tests_failed++;
            $display("FAIL reset_mid_restart: got edge %0d v%b o%b %h expected edge 11 v1 o0 3c", de, o_valid, o_ovf, o_val);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_rounding();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/simple_fixed_point_signed_multiplier.md
# simple_fixed_point_signed_multiplier

Sequential signed fixed-point multiplier, the inverse companion of the team's long-division divider, sharing its start/busy/done/valid handshake and Q-format conventions. It computes `a*b` in Q(WIDTH-FBITS).FBITS with shift-and-add over sign-magnitude operands, Gaussian (round-half-to-even) rounding and overflow detection. It sits in DSP datapaths (filter gain and coefficient scaling) where area matters more than throughput.

## Interface
- `WIDTH`, 8: total operand/result width in bits (integer + fractional); must be ≥ 3.
- `FBITS`, 4: fractional bits within WIDTH, 0 ≤ FBITS < WIDTH.
- `i_clk` input 1: clock; all state changes on rising edge.
- `i_rst` input 1: reset, asynchronous, active-high.
- `i_start` input 1: start request, sampled only in IDLE.
- `a` input WIDTH signed: multiplicand.
- `b` input WIDTH signed: multiplier.
- `o_busy` output 1: calculation in progress.
- `o_done` output 1: one-cycle pulse at the end of every accepted request.
- `o_valid` output 1: `o_val` holds the result of the last request.
- `o_ovf` output 1: last request overflowed.
- `o_val` output WIDTH signed: rounded product.

## Operation
- Definitions: WIDTHU = WIDTH-1; SMALLEST = 1 followed by WIDTHU zeros.
- States: IDLE, INIT, CALC, ROUND, SIGN.
- IDLE + `i_start`: `o_valid`←0, `o_ovf`←0. If `a` or `b` == SMALLEST: stay IDLE, `o_done`←1, `o_ovf`←1. Otherwise register `au`=|a|, `bu`=|b| (WIDTHU bits each), `sig_diff`=a_sign^b_sign, `o_busy`←1, go to INIT.
- INIT: clear 2·WIDTHU-bit unsigned product `P`, iteration counter ←0; go to CALC.
- CALC: one iteration per cycle, WIDTHU iterations: if `bu[i]` then `P += au << i`. After iteration WIDTHU-1, go to ROUND.
- ROUND (FBITS>0): `m = P >> FBITS`; guard = `P[FBITS-1]`; sticky = OR of `P[FBITS-2:0]` (0 when FBITS=1); `m += 1` iff guard && (`m[0]` || sticky). FBITS=0: `m = P`. Overflow iff `m ≥ 2^WIDTHU`, including carry from rounding; go to SIGN.
- SIGN: `o_busy`←0, `o_done`←1. No overflow: `o_val` ← (sig_diff && m≠0) ? -m : m, sign-extended to WIDTH, and `o_valid`←1. Overflow: `o_ovf`←1, plus the configuration-dependent behaviour below. Go to IDLE.
- `i_start` outside IDLE is ignored. `a`/`b` only need to be stable in the cycle `i_start` is sampled.
- A zero operand follows the normal path and yields `o_val`=0, positive.

## Timing
- Reset values: `o_busy`=0, `o_done`=0, `o_valid`=0, `o_ovf`=0, `o_val`=0, state IDLE, counter 0.
- Latency: count the edge that samples `i_start` as edge 1. `o_done` is visible after edge WIDTHU+4 (11 for WIDTH=8). `o_busy` is high after edges 1 through WIDTHU+3.
- SMALLEST-operand rejection: `o_done` and `o_ovf` are visible after edge 1, and `o_busy` never rises.
- Back-to-back: `i_start` held high is accepted in the cycle after `o_done`, since state is already IDLE.
- Reset mid-operation: all outputs and state return to reset values immediately. No `o_done` is produced for the aborted request.
- `o_val`, `o_valid` and `o_ovf` hold until the next accepted `i_start` or reset.

## Configuration
- `MULT_SATURATE_EN` defined: on product overflow, `o_val` saturates to +max (0 then all ones) if sig_diff=0, or to −max (1, zeros, then final 1) if sig_diff=1. `o_valid`←1 and `o_ovf`←1. SMALLEST-operand rejection also saturates by the same rule.
- Not defined: on overflow `o_val` keeps its previous value, `o_valid` stays 0 and `o_ovf`←1.

## Structure
- Shared package `fixed_point_pkg`:
  - state enum (IDLE/INIT/CALC/ROUND/SIGN), shared with the divider;
  - helper functions for WIDTHU and the SMALLEST constant.
- Sub-module `fixed_point_round_half_even`:
  - combinational;
  - parameters: input width, FBITS;
  - outputs: rounded magnitude and carry/overflow;
  - reusable by other Q-format blocks.

## Test plan
All cases use WIDTH=8, FBITS=4.
- a=0x28 (2.5), b=0x18 (1.5) → `o_val`=0x3C (3.75), `o_valid`=1, `o_ovf`=0, `o_done` after edge 11.
- a=0xD8 (−2.5), b=0x18 → `o_val`=0xC4 (−3.75). a=0xD8, b=0xE8 (−1.5) → `o_val`=0x3C.
- Ties:
  - a=0x01, b=0x18: P=24, tie with odd lsb → 0x02;
  - a=0x01, b=0x08: P=8, tie with even lsb → 0x00, positive zero.
- a=0x40 (4.0), b=0x20 (2.0):
  - both configurations: `o_ovf`=1;
  - without `MULT_SATURATE_EN`: `o_valid`=0 and `o_val` unchanged;
  - with it: `o_val`=0x7F, `o_valid`=1.
- a=0x80, b=0x10 → `o_done`+`o_ovf` after edge 1, `o_busy` never high. Then a=0x10, b=0x10 with `i_start` held high → 0x10 after 11 edges.
- Assert `i_rst` at CALC edge 5 → all outputs 0 immediately, no `o_done`. A new start afterwards completes normally.
